// File: rtl/clk_powerdn_ctrl.sv
// Multi-channel clock power-down controller: per-channel registered clock
// enables with idle timeout, wake latency, and power-accounting counters.

module clk_powerdn_ch #(
   parameter int IDLE_W   = 8,
   parameter int WAKE_LAT = 2,
   parameter int WK_W     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ch_en,
   input  logic              ch_busy,
   input  logic              wake_req,
   input  logic [IDLE_W-1:0] idle_limit,
   output logic              gate_en,
   output logic              wake_ack,
   output logic [1:0]        ch_state
);

   typedef enum logic [1:0] {
      GATED = 2'b00,
      RUN   = 2'b01,
      IDLE  = 2'b10,
      WAKE  = 2'b11
   } pd_state_e;

   pd_state_e         state_q;
   pd_state_e         state_d;
   logic [IDLE_W-1:0] idle_q;
   logic [IDLE_W-1:0] idle_d;
   logic [WK_W-1:0]   wake_q;
   logic [WK_W-1:0]   wake_d;
   logic              gate_q;
   logic              gate_d;
   logic              ack_q;
   logic              ack_d;
   logic [IDLE_W:0]   idle_nx;
   logic              lim_zero;
   logic              lim_one;
   logic              stay_on;

   assign idle_nx  = {1'b0, idle_q} + (IDLE_W+1)'(1);
   assign lim_zero = (idle_limit == '0);
   assign lim_one  = (idle_limit == IDLE_W'(1));
   assign stay_on  = ch_busy | lim_zero;

   // next-state, timer updates and registered output values
   always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      wake_d  = wake_q;
      if (!ch_en) begin
         state_d = GATED;
         idle_d  = '0;
         wake_d  = '0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (!stay_on) begin
                  if (lim_one) begin
                     state_d = GATED;
                  end else begin
                     state_d = IDLE;
                     idle_d  = IDLE_W'(1);
                  end
               end
            end
            IDLE: begin
               if (stay_on) begin
                  state_d = RUN;
                  idle_d  = '0;
               end else if (idle_nx >= {1'b0, idle_limit}) begin
                  state_d = GATED;
                  idle_d  = '0;
               end else begin
                  idle_d = idle_nx[IDLE_W-1:0];
               end
            end
            GATED: begin
               if (wake_req | ch_busy) begin
                  state_d = WAKE;
                  wake_d  = '0;
               end
            end
            WAKE: begin
               if (wake_q == WK_W'(WAKE_LAT)) begin
                  state_d = RUN;
                  wake_d  = '0;
               end else begin
                  wake_d = wake_q + WK_W'(1);
               end
            end
         endcase
      end
      gate_d = (state_d == RUN) | (state_d == IDLE);
      ack_d  = (state_q == WAKE) & (state_d == RUN);
   end

   // state, timers and registered enable/ack
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         idle_q  <= '0;
         wake_q  <= '0;
         gate_q  <= 1'b1;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idle_q  <= idle_d;
         wake_q  <= wake_d;
         gate_q  <= gate_d;
         ack_q   <= ack_d;
      end
   end

   assign gate_en  = gate_q;
   assign wake_ack = ack_q;
   assign ch_state = state_q;

endmodule

module clk_powerdn_ctrl #(
   parameter int          NCH      = 4,
   parameter int          CNT_W    = 32,
   parameter int          IDLE_W   = 8,
   parameter int          WAKE_LAT = 2,
   parameter logic [31:0] CNT_INIT = 32'h1000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH-1:0]       ch_en,
   input  logic [NCH-1:0]       ch_busy,
   input  logic [NCH-1:0]       wake_req,
   input  logic [IDLE_W-1:0]    idle_limit,
   output logic [NCH-1:0]       gate_en,
   output logic [NCH-1:0]       wake_ack,
   output logic [2*NCH-1:0]     ch_state,
   output logic [NCH*CNT_W-1:0] gated_cnt,
   output logic [CNT_W-1:0]     total_cnt
);

   localparam int WK_W = $clog2(WAKE_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(CNT_INIT);

   logic [CNT_W-1:0] total_q;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [CNT_W-1:0] gcnt_q;

      clk_powerdn_ch #(
         .IDLE_W   (IDLE_W),
         .WAKE_LAT (WAKE_LAT),
         .WK_W     (WK_W)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .ch_en      (ch_en[g]),
         .ch_busy    (ch_busy[g]),
         .wake_req   (wake_req[g]),
         .idle_limit (idle_limit),
         .gate_en    (gate_en[g]),
         .wake_ack   (wake_ack[g]),
         .ch_state   (ch_state[2*g +: 2])
      );

      // count cycles the channel clock was enabled
      always_ff @(posedge clk) begin
         if (reset) begin
            gcnt_q <= CNT_RST;
         end else if (gate_en[g]) begin
            gcnt_q <= gcnt_q + CNT_W'(1);
         end
      end

      assign gated_cnt[CNT_W*g +: CNT_W] = gcnt_q;
   end

   // free-running reference cycle counter
   always_ff @(posedge clk) begin
      if (reset) begin
         total_q <= CNT_RST;
      end else begin
         total_q <= total_q + CNT_W'(1);
      end
   end

   assign total_cnt = total_q;

endmodule
